sipo_shift_reg: RTL and testbench

- Serial-in, parallel-out shift register that deserialises a 1-bit stream into a WIDTH-bit word.
- Used at serial receive front-ends: each enabled clock captures one bit.
- A word-complete strobe and a bit counter tell downstream logic when a full word is assembled.

---
 rtl/sipo_shift_reg.sv | 57 +++++
 tb/tb_sipo_shift_reg.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/sipo_shift_reg.sv
// Serial-in, parallel-out deserialiser: one bit per enabled clock, a word-complete
// strobe after every WIDTH captured bits, and a running bit count within the word.
module sipo_shift_reg #(
   parameter int  WIDTH      = 4,
   parameter bit  SHIFT_LEFT = 1'b1,
   localparam int CNT_W      = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             serial_in,
   output logic [WIDTH-1:0] parallel_out,
   output logic [CNT_W-1:0] bit_count,
   output logic             word_valid
);

   logic [WIDTH-1:0] shift_p0;
   logic [CNT_W-1:0] cnt_p0;
   logic             vld_p0;
   logic             last_bit;

   // Insert one bit; the bit at the far end falls off.
   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                 input logic             b);
      if (SHIFT_LEFT)
         return {cur[WIDTH-2:0], b};
      else
         return {b, cur[WIDTH-1:1]};
   endfunction

   assign last_bit = (cnt_p0 == CNT_W'(WIDTH - 1));

   // Stage p0: capture register, bit counter and word-complete strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_p0 <= '0;
         cnt_p0   <= '0;
         vld_p0   <= 1'b0;
      end else begin
         vld_p0 <= 1'b0;
         if (en) begin
            shift_p0 <= shift_in(shift_p0, serial_in);
            if (last_bit) begin
               cnt_p0 <= '0;
               vld_p0 <= 1'b1;
            end else begin
               cnt_p0 <= cnt_p0 + CNT_W'(1);
            end
         end
      end
   end

   assign parallel_out = shift_p0;
   assign bit_count    = cnt_p0;
   assign word_valid   = vld_p0;

endmodule

// File: tb/tb_sipo_shift_reg.sv
// Bench for sipo_shift_reg: both shift directions side by side, directed scenarios
// plus random traffic, all compared against a bit-history reference model.
module tb_sipo_shift_reg;

   localparam int W     = 4;
   localparam int CNT_W = $clog2(W + 1);

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b0;
   logic             serial_in = 1'b0;
   logic [W-1:0]     pl_out, pr_out;
   logic [CNT_W-1:0] cl_out, cr_out;
   logic             vl_out, vr_out;

   int n_chk  = 0;
   int n_fail = 0;
   int cycle  = 0;

   // Reference model: history of captured bits since the last reset.
   bit hist[$];
   bit valid_m = 1'b0;

   always #5 clk = ~clk;

   sipo_shift_reg #(.WIDTH(W), .SHIFT_LEFT(1'b1)) dut_l (
      .clk(clk), .rst(rst), .en(en), .serial_in(serial_in),
      .parallel_out(pl_out), .bit_count(cl_out), .word_valid(vl_out));

   sipo_shift_reg #(.WIDTH(W), .SHIFT_LEFT(1'b0)) dut_r (
      .clk(clk), .rst(rst), .en(en), .serial_in(serial_in),
      .parallel_out(pr_out), .bit_count(cr_out), .word_valid(vr_out));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
      end
   endtask

   // Newest bit at LSB for left shift; the newest W bits of history, zero-filled.
   function automatic logic [W-1:0] exp_word(input bit left);
      logic [W-1:0] v = '0;
      int n = hist.size();
      for (int i = 0; i < W; i++)
         if (i < n) begin
            if (left) v[i] = hist[n-1-i];
            else      v[W-1-i] = hist[n-1-i];
         end
      return v;
   endfunction

   task automatic model_check();
      logic [W-1:0] el, er;
      logic [CNT_W-1:0] ec;
      el = exp_word(1'b1);
      er = exp_word(1'b0);
      ec = CNT_W'(hist.size() % W);
      chk("left_data", 32'(pl_out), 32'(el));
      chk("left_cnt",  32'(cl_out), 32'(ec));
      chk("left_vld",  32'(vl_out), 32'(valid_m));
      chk("right_data", 32'(pr_out), 32'(er));
      chk("right_cnt",  32'(cr_out), 32'(ec));
      chk("right_vld",  32'(vr_out), 32'(valid_m));
   endtask

   // Apply one cycle of inputs, advance the model, then check after the edge.
   task automatic step(input logic r, input logic e, input logic s);
      rst = r; en = e; serial_in = s;
      @(posedge clk);
      cycle++;
      if (r) begin
         hist.delete();
         valid_m = 1'b0;
      end else if (e) begin
         hist.push_back(s);
         valid_m = (hist.size() % W) == 0;
      end else begin
         valid_m = 1'b0;
      end
      #1;
      model_check();
   endtask

   initial begin
      logic [W-1:0] basic_bits = 4'b1011;
      logic [W-1:0] l_exp[4]   = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
      logic [W-1:0] r_exp[4]   = '{4'b1000, 4'b0100, 4'b1010, 4'b1101};
      logic [CNT_W-1:0] c_exp[4] = '{1, 2, 3, 0};
      logic [11:0] stream = 12'b1011_0110_1111;
      logic [W-1:0] word_exp[3] = '{4'b1011, 4'b0110, 4'b1111};
      int pulses, last_pulse;

      // Reset state and basic load in both directions
      step(1'b1, 1'b0, 1'b0);
      chk("rst_data", 32'(pl_out), 32'h0);
      chk("rst_cnt",  32'(cl_out), 32'h0);
      chk("rst_vld",  32'(vl_out), 32'h0);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, basic_bits[3-i]);
         chk("basic_l", 32'(pl_out), 32'(l_exp[i]));
         chk("basic_r", 32'(pr_out), 32'(r_exp[i]));
         chk("basic_cnt", 32'(cl_out), 32'(c_exp[i]));
         chk("basic_vld", 32'(vl_out), (i == 3) ? 32'h1 : 32'h0);
      end

      // Hold with serial_in toggling
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b0, i[0] ? 1'b0 : 1'b1);
         chk("hold_data", 32'(pl_out), 32'hb);
         chk("hold_cnt",  32'(cl_out), 32'h0);
         chk("hold_vld",  32'(vl_out), 32'h0);
      end

      // Mid-word reset has priority over enable
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      chk("mid_data", 32'(pl_out), 32'h3);
      chk("mid_cnt",  32'(cl_out), 32'h2);
      step(1'b1, 1'b1, 1'b1);
      chk("rstpri_data", 32'(pl_out), 32'h0);
      chk("rstpri_cnt",  32'(cl_out), 32'h0);
      chk("rstpri_vld",  32'(vl_out), 32'h0);
      step(1'b0, 1'b0, 1'b0);
      chk("rstpri_novld", 32'(vl_out), 32'h0);

      // Gapped enable: 1,0, three idle cycles, 0,1
      pulses = 0;
      step(1'b0, 1'b1, 1'b1); pulses += int'(vl_out);
      step(1'b0, 1'b1, 1'b0); pulses += int'(vl_out);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b1); pulses += int'(vl_out);
      end
      step(1'b0, 1'b1, 1'b0); pulses += int'(vl_out);
      chk("gap_prevld", 32'(pulses), 32'h0);
      step(1'b0, 1'b1, 1'b1);
      chk("gap_data", 32'(pl_out), 32'h9);
      chk("gap_vld",  32'(vl_out), 32'h1);
      step(1'b0, 1'b0, 1'b0);
      chk("gap_vld_once", 32'(vl_out), 32'h0);

      // Continuous stream of three words
      step(1'b1, 1'b0, 1'b0);
      pulses = 0; last_pulse = -1;
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 1'b1, stream[11-i]);
         if (vl_out) begin
            if (pulses < 3) chk("stream_word", 32'(pl_out), 32'(word_exp[pulses]));
            if (last_pulse >= 0) chk("stream_gap", 32'(cycle - last_pulse), 32'd4);
            last_pulse = cycle;
            pulses++;
         end
      end
      chk("stream_pulses", 32'(pulses), 32'd3);

      // Random traffic with occasional resets
      for (int i = 0; i < 2000; i++)
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 1'($urandom));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
